// File: rtl/mpalu_cmd_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : mpalu_cmd_sequencer
// Brief    : Queues ALU requests in a small FIFO, issues them one at a time on
//            the ALU operand bus and returns {result, tag, err} in order.
// Revision : 1.0 - initial release
// =============================================================================
module mpalu_cmd_sequencer #(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 3,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic              busy
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(DEPTH);
    localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_lat     = c_cnt_w'(ALU_LAT);
    localparam logic [c_cnt_w-1:0] c_lat_one = c_cnt_w'(1);

    localparam logic [OP_W-1:0] c_op_add = OP_W'(0);
    localparam logic [OP_W-1:0] c_op_mul = OP_W'(5);
    localparam logic [OP_W-1:0] c_op_max = OP_W'(6);
    localparam logic [OP_W-1:0] c_op_min = OP_W'(7);

    typedef enum logic [1:0] {
        s_idle = 2'd0,
        s_wait = 2'd1,
        s_resp = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Command FIFO
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem_a   [DEPTH];
    logic [DATA_W-1:0] r_mem_b   [DEPTH];
    logic [OP_W-1:0]   r_mem_op  [DEPTH];
    logic [TAG_W-1:0]  r_mem_tag [DEPTH];

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    logic [DATA_W-1:0] w_head_a;
    logic [DATA_W-1:0] w_head_b;
    logic [OP_W-1:0]   w_head_op;
    logic [TAG_W-1:0]  w_head_tag;
    logic              w_head_legal;

    state_t r_state;
    state_t w_state_nxt;

    assign w_full    = (r_count == c_depth);
    assign w_empty   = (r_count == '0);
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = (r_state == s_idle) && !w_empty;

    assign w_head_a     = r_mem_a[r_rd_ptr];
    assign w_head_b     = r_mem_b[r_rd_ptr];
    assign w_head_op    = r_mem_op[r_rd_ptr];
    assign w_head_tag   = r_mem_tag[r_rd_ptr];
    assign w_head_legal = (w_head_op == c_op_add) || (w_head_op == c_op_mul) ||
                          (w_head_op == c_op_max) || (w_head_op == c_op_min);

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]   <= cmd_a;
            r_mem_b[r_wr_ptr]   <= cmd_b;
            r_mem_op[r_wr_ptr]  <= cmd_op;
            r_mem_tag[r_wr_ptr] <= cmd_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Issue / wait / respond sequencer
    // -------------------------------------------------------------------------
    logic [c_cnt_w-1:0] r_cnt;
    logic [TAG_W-1:0]   r_tag;

    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [TAG_W-1:0]   w_tag_nxt;
    logic [DATA_W-1:0]  w_alu_a_nxt;
    logic [DATA_W-1:0]  w_alu_b_nxt;
    logic [OP_W-1:0]    w_alu_op_nxt;
    logic [DATA_W-1:0]  w_rsp_result_nxt;
    logic [TAG_W-1:0]   w_rsp_tag_nxt;
    logic               w_rsp_err_nxt;

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_tag_nxt        = r_tag;
        w_alu_a_nxt      = alu_a;
        w_alu_b_nxt      = alu_b;
        w_alu_op_nxt     = alu_opcode;
        w_rsp_result_nxt = rsp_result;
        w_rsp_tag_nxt    = rsp_tag;
        w_rsp_err_nxt    = rsp_err;

        unique case (r_state)
            s_idle: begin
                if (!w_empty) begin
                    if (w_head_legal) begin
                        w_alu_a_nxt  = w_head_a;
                        w_alu_b_nxt  = w_head_b;
                        w_alu_op_nxt = w_head_op;
                        w_cnt_nxt    = '0;
                        w_tag_nxt    = w_head_tag;
                        w_state_nxt  = s_wait;
                    end else begin
                        // Reserved opcode never reaches the ALU bus.
                        w_rsp_result_nxt = '0;
                        w_rsp_err_nxt    = 1'b1;
                        w_rsp_tag_nxt    = w_head_tag;
                        w_state_nxt      = s_resp;
                    end
                end
            end
            s_wait: begin
                if (r_cnt == c_lat) begin
                    w_rsp_result_nxt = alu_result;
                    w_rsp_tag_nxt    = r_tag;
                    w_rsp_err_nxt    = 1'b0;
                    w_state_nxt      = s_resp;
                end else begin
                    w_cnt_nxt = r_cnt + c_lat_one;
                end
            end
            s_resp: begin
                if (rsp_ready) begin
                    w_state_nxt = s_idle;
                end
            end
            default: begin
                w_state_nxt = s_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= s_idle;
            r_cnt      <= '0;
            r_tag      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_result <= '0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tag      <= w_tag_nxt;
            alu_a      <= w_alu_a_nxt;
            alu_b      <= w_alu_b_nxt;
            alu_opcode <= w_alu_op_nxt;
            rsp_result <= w_rsp_result_nxt;
            rsp_tag    <= w_rsp_tag_nxt;
            rsp_err    <= w_rsp_err_nxt;
        end
    end

    assign rsp_valid = (r_state == s_resp);
    assign busy      = !w_empty || (r_state != s_idle);

endmodule

`default_nettype wire
